sha256_link: RTL

SHA256_LINK -- requirements
Module: sha256_link

---
 rtl/sha256_link.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sha256_link.sv
// sha256_link: serialises a wide message into 10-bit words for a hash core and
// reassembles the 10-bit hash words it returns into a 256-bit digest.
module sha256_link #(
  parameter int unsigned MESSAGE_LEN    = 640,
  parameter int unsigned HASH_WORDS     = 26,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [MESSAGE_LEN-1:0] req_message,
  output logic                   req_ready,
  output logic                   core_start,
  output logic                   core_valid_in,
  output logic [9:0]             core_message,
  input  logic                   core_valid_out,
  input  logic [9:0]             core_hash,
  output logic [255:0]           digest,
  output logic                   digest_valid,
  output logic                   timeout_err
);

  localparam int unsigned MSG_WORDS = MESSAGE_LEN / 10;
  localparam int unsigned BUF_W     = 10 * HASH_WORDS;
  localparam int unsigned MCNT_W    = $clog2(MSG_WORDS + 1);
  localparam int unsigned HCNT_W    = $clog2(HASH_WORDS + 1);
  localparam int unsigned TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MSG_WORDS - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HASH_WORDS - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT_HASH,
    RECV,
    DONE
  } state_t;

  state_t state, state_next;

  logic [MESSAGE_LEN-1:0] msg_reg;
  logic [BUF_W-1:0]       hash_buf;
  logic [BUF_W-1:0]       buf_next;
  logic [MCNT_W-1:0]      mcnt;
  logic [HCNT_W-1:0]      hcnt;
  logic [TCNT_W-1:0]      tcnt;
  logic                   capture;
  logic                   last_word;
  logic                   waiting;

  // Hash words arrive MSB-first, so shifting left leaves word 0 at the top.
  assign buf_next = {hash_buf[BUF_W-11:0], core_hash};
  assign waiting  = (state == WAIT_HASH) || (state == RECV);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    core_start    = 1'b0;
    core_valid_in = 1'b0;
    core_message  = '0;
    digest_valid  = 1'b0;
    timeout_err   = 1'b0;
    capture       = 1'b0;
    last_word     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = START;
      end
      START: begin
        core_start = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        core_valid_in = 1'b1;
        core_message  = msg_reg[MESSAGE_LEN-1 -: 10];
        if (mcnt == MCNT_LAST) state_next = WAIT_HASH;
      end
      WAIT_HASH, RECV: begin
        if (core_valid_out) begin
          capture = 1'b1;
          if (hcnt == HCNT_LAST) begin
            last_word  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = RECV;
          end
        end
        // A final word arriving on the timeout cycle still completes.
        if (!last_word && tcnt == TCNT_LAST) begin
          timeout_err = 1'b1;
          state_next  = IDLE;
        end
      end
      DONE: begin
        digest_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Message shift register, hash reassembly, digest and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_reg  <= '0;
      hash_buf <= '0;
      digest   <= '0;
      mcnt     <= '0;
      hcnt     <= '0;
      tcnt     <= '0;
    end else begin
      if (state == IDLE && req_valid) msg_reg <= req_message;

      if (state == SEND) begin
        msg_reg <= {msg_reg[MESSAGE_LEN-11:0], 10'd0};
        mcnt    <= (mcnt == MCNT_LAST) ? '0 : mcnt + 1'b1;
      end else begin
        mcnt <= '0;
      end

      if (waiting) begin
        tcnt <= tcnt + 1'b1;
        if (capture) begin
          hash_buf <= buf_next;
          hcnt     <= hcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
        hcnt <= '0;
      end

      if (last_word) digest <= buf_next[BUF_W-1 -: 256];
    end
  end

endmodule
